// File: rtl/seq_multiplier.sv
// Sequential unsigned shift-add multiplier: one multiplier bit per clock, product held until ena drops.
// Optional macro SEQ_MULT_EARLY_TERM_EN finishes RUN as soon as the remaining multiplier bits are zero.
module seq_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic               CLK,
  input  logic               rst,
  input  logic               ena,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] Y,
  output logic               done,
  output logic [1:0]         state_o
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t               r_state, w_state_nxt;
  logic [2*WIDTH-1:0]   r_mcand, r_acc, r_y, w_acc_nxt;
  logic [WIDTH-1:0]     r_mplier, w_mplier_shr;
  logic [CW-1:0]        r_cnt, w_cnt_inc;
  logic                 r_done, w_finish;

  always_comb begin
    w_acc_nxt    = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    w_mplier_shr = r_mplier >> 1;
    w_cnt_inc    = r_cnt + CW'(1);
`ifdef SEQ_MULT_EARLY_TERM_EN
    w_finish     = (w_cnt_inc == CNT_LAST) || (w_mplier_shr == '0);
`else
    w_finish     = (w_cnt_inc == CNT_LAST);
`endif
    w_state_nxt  = r_state;
    case (r_state)
      IDLE:    if (ena) w_state_nxt = RUN;
      RUN:     if (!ena) w_state_nxt = IDLE;
               else if (w_finish) w_state_nxt = DONE;
      DONE:    if (!ena) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Y only changes on the RUN->DONE step; an abort leaves the previous product in place.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_y      <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= (w_state_nxt == DONE);
      case (r_state)
        IDLE: if (ena) begin
          r_mcand  <= {{WIDTH{1'b0}}, A};
          r_mplier <= B;
          r_acc    <= '0;
          r_cnt    <= '0;
        end
        RUN: if (ena) begin
          r_acc    <= w_acc_nxt;
          r_mcand  <= r_mcand << 1;
          r_mplier <= w_mplier_shr;
          r_cnt    <= w_cnt_inc;
          if (w_finish) r_y <= w_acc_nxt;
        end
        default: ;
      endcase
    end
  end

  assign Y       = r_y;
  assign done    = r_done;
  assign state_o = r_state;
endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier (WIDTH=4): products queued at capture, popped when done rises.
module tb_seq_multiplier;
  logic       CLK, rst, ena;
  logic [3:0] A, B;
  logic [7:0] Y;
  logic       done;
  logic [1:0] state_o;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_y = 8'h00;

  seq_multiplier #(.WIDTH(4)) dut (
    .CLK(CLK), .rst(rst), .ena(ena), .A(A), .B(B),
    .Y(Y), .done(done), .state_o(state_o)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic int exp_lat(input logic [3:0] b);
    int l;
    l = 4;
`ifdef SEQ_MULT_EARLY_TERM_EN
    l = 1;
    for (int i = 0; i < 4; i++) if (b[i]) l = i + 1;
`endif
    return l;
  endfunction

  // One full request: capture, wait for done, hold ena, then release.
  task automatic run_req(input logic [3:0] a, input logic [3:0] b, input int hold, input string nm);
    int n;
    int lat;
    logic [7:0] exp;
    lat = exp_lat(b);
    A = a; B = b; ena = 1'b1;
    exp_q.push_back({4'b0, a} * {4'b0, b});
    @(posedge CLK); #1;
    n = 0;
    while (!done && n < 20) begin
      checks++;
      if (Y !== last_y) begin
        errors++;
        $display("FAIL %s_y_hold_run: Y=%h expected %h", nm, Y, last_y);
      end
      @(posedge CLK); #1;
      n++;
    end
    checks++;
    if (n !== lat) begin
      errors++;
      $display("FAIL %s_latency: got %0d edges expected %0d", nm, n, lat);
    end
    exp = exp_q.pop_front();
    checks++;
    if (Y !== exp || state_o !== 2'd2) begin
      errors++;
      $display("FAIL %s_product: Y=%h state=%0d expected Y=%h state=2", nm, Y, state_o, exp);
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge CLK); #1;
      checks++;
      if (done !== 1'b1 || Y !== exp || state_o !== 2'd2) begin
        errors++;
        $display("FAIL %s_hold: done=%b Y=%h state=%0d expected done=1 Y=%h state=2", nm, done, Y, state_o, exp);
      end
    end
    ena = 1'b0;
    @(posedge CLK); #1;
    checks++;
    if (done !== 1'b0 || state_o !== 2'd0 || Y !== exp) begin
      errors++;
      $display("FAIL %s_release: done=%b state=%0d Y=%h expected done=0 state=0 Y=%h", nm, done, state_o, Y, exp);
    end
    last_y = exp;
  endtask

  task automatic test_reset_init();
    #3;
    checks++;
    if (Y !== 8'h00 || done !== 1'b0 || state_o !== 2'd0) begin
      errors++;
      $display("FAIL reset_init: Y=%h done=%b state=%0d expected 00/0/0", Y, done, state_o);
    end
    #9 rst = 1'b0;
  endtask

  task automatic test_basic();
    run_req(4'd3, 4'd5, 0, "basic");
  endtask

  task automatic test_max_zero();
    run_req(4'd15, 4'd15, 0, "max");
    run_req(4'd0, 4'd9, 0, "zero");
  endtask

  task automatic test_hold();
    run_req(4'd5, 4'd3, 10, "hold");
  endtask

  task automatic test_abort();
    A = 4'd6; B = 4'd6; ena = 1'b1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    ena = 1'b0;
    @(posedge CLK); #1;
    checks++;
    if (state_o !== 2'd0 || done !== 1'b0 || Y !== last_y) begin
      errors++;
      $display("FAIL abort: state=%0d done=%b Y=%h expected 0/0/%h", state_o, done, Y, last_y);
    end
    @(posedge CLK); #1;
    checks++;
    if (done !== 1'b0 || Y !== last_y) begin
      errors++;
      $display("FAIL abort_idle: done=%b Y=%h expected 0/%h", done, Y, last_y);
    end
    run_req(4'd2, 4'd4, 0, "after_abort");
  endtask

  task automatic test_reset_midrun();
    A = 4'd7; B = 4'd9; ena = 1'b1;
    @(posedge CLK); #1;
    @(posedge CLK); #2;
    rst = 1'b1;
    #1;
    checks++;
    if (Y !== 8'h00 || done !== 1'b0 || state_o !== 2'd0) begin
      errors++;
      $display("FAIL reset_midrun: Y=%h done=%b state=%0d expected 00/0/0", Y, done, state_o);
    end
    ena = 1'b0;
    #10 rst = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if (Y !== 8'h00 || done !== 1'b0 || state_o !== 2'd0) begin
      errors++;
      $display("FAIL reset_release: Y=%h done=%b state=%0d expected 00/0/0", Y, done, state_o);
    end
    last_y = 8'h00;
  endtask

  task automatic test_early_term();
    run_req(4'd9, 4'd0, 0, "b0");
    run_req(4'd7, 4'd2, 0, "b2");
    run_req(4'd15, 4'd8, 0, "b8");
    run_req(4'd11, 4'd1, 0, "b1");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++)
      run_req(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 0, "b2b");
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left expected 0", exp_q.size());
    end
  endtask

  initial begin
    rst = 1'b1; ena = 1'b0; A = '0; B = '0;
    test_reset_init();
    test_basic();
    test_max_zero();
    test_hold();
    test_abort();
    test_reset_midrun();
    test_early_term();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Sequential unsigned shift-add multiplier that sits directly downstream of the dual-port RAM controller in the DE1-SoC multiplier design. It accepts operands A and B together with the `ena` request level from the controller. It computes Y = A × B one multiplier bit per clock, then raises `done` and holds the product stable until the controller drops `ena`.

## Interface
- `WIDTH`, default 4: operand width in bits. Y is 2·WIDTH bits wide.
- `CLK`: input, 1 bit. Single clock; all state updates on the rising edge.
- `rst`: input, 1 bit. Asynchronous, active-high reset.
- `ena`: input, 1 bit. Request level from the controller; must stay high until `done` is seen.
- `A`: input, WIDTH bits. Multiplicand; sampled only on the capture edge.
- `B`: input, WIDTH bits. Multiplier; sampled only on the capture edge.
- `Y`: output, 2·WIDTH bits. Registered product.
- `done`: output, 1 bit. Registered result-valid level.
- `state_o`: output, 2 bits. Current FSM state, for debug/LED use.

## Operation
- FSM states and encodings: IDLE=0, RUN=1, DONE=2. Encoding 3 is unused and recovers to IDLE on the next edge.
- Internal registers:
  - mcand: 2·WIDTH bits, holds A zero-extended.
  - mplier: WIDTH bits, holds B.
  - acc: 2·WIDTH bits, running sum.
  - cnt: sized to count 0..WIDTH.
- IDLE:
  - On an edge with `ena`=1: mcand←{0,A}, mplier←B, acc←0, cnt←0, go to RUN.
  - `ena`=0: stay in IDLE.
  - `done`=0 throughout.
- RUN, each edge:
  - If mplier[0]=1: acc←acc+mcand.
  - Then mcand←mcand<<1, mplier←mplier>>1, cnt←cnt+1.
  - On the edge where cnt reaches WIDTH: Y←final acc (including this step's add), `done`←1, go to DONE.
- DONE:
  - Hold Y; `done`=1 while `ena`=1.
  - First edge with `ena`=0: `done`←0, go to IDLE.
  - No new capture while `ena` stays high, so one request produces exactly one product.
- `ena` dropped during RUN: abort to IDLE on that edge. `done` stays 0 and Y keeps its previous value.
- Y updates only on entry to DONE. It keeps the last product through IDLE, a new RUN and any abort.
- Arithmetic:
  - Unsigned, no overflow possible (max (2^W−1)² < 2^(2W)).
  - Adder and shifter are 2·WIDTH bits wide; carries out of bit 2·WIDTH−1 are impossible and are dropped.

## Timing
- Reset (async, any time, including mid-RUN):
  - state=IDLE, Y=0, `done`=0, state_o=0.
  - acc=0, mcand=0, mplier=0, cnt=0.
- Reset release: the first edge with rst=0 and `ena`=1 captures the operands.
- Latency without early termination:
  - Capture edge C; `done` and Y are valid after edge C+WIDTH.
  - For WIDTH=4 that is 5 edges including capture.
- `done` deasserts one edge after `ena` is sampled low.
- Y is stable from `done`↑ until the next DONE entry, which covers the controller's write two cycles later.
- Minimum request period: WIDTH+2 cycles (capture, WIDTH steps, one cycle of DONE with `ena` low).

## Configuration
- Macro: `SEQ_MULT_EARLY_TERM_EN`.
- Defined:
  - In RUN, the FSM also goes to DONE on the edge where the shifted mplier becomes 0, even if cnt<WIDTH.
  - Latency becomes max(1, index of B's highest set bit + 1) RUN edges after capture.
  - B=0 or B=1 finish on the first RUN edge.
  - Products are identical to the non-terminating build.
- Undefined: always exactly WIDTH RUN edges, independent of operand values.

## Test plan
- Reset: assert rst mid-RUN with A=7, B=9 → Y=0x00, `done`=0 and state_o=0 immediately, with no clock edge needed; after release with `ena`=0, nothing changes.
- Basic (WIDTH=4, macro off): A=3, B=5, `ena`↑ → `done`=1 exactly 4 edges after capture; Y=0x0F; Y stable until `ena`↓; `done`=0 one edge later.
- Maximum operands: A=15, B=15 → Y=0xE1. Zero operands: A=0, B=9 → Y=0x00. Both take full latency with the macro off.
- `ena` held high for 10 cycles after `done` → `done` stays 1 and Y unchanged; no second computation starts.
- Abort: `ena`↓ after 2 RUN edges with A=6, B=6 → IDLE, `done`=0, Y keeps the prior product; a new request A=2, B=4 → Y=0x08.
- Macro on:
  - B=0 → `done` one RUN edge after capture, Y=0x00.
  - B=2, A=7 → done after 2 RUN edges, Y=0x0E.
  - B=8, A=15 → done after 4 RUN edges, Y=0x78.
